// File: rtl/dcj11_bus_initiator_pkg.sv
// ----------------------------------------------------------------------------
// dcj11_pkg
//   Shared definitions for the DCJ11 DAL bus initiator and its companions:
//   AIO cycle codes, bank-select codes, the initiator state encoding and the
//   packing of the high address word as it appears on DAL.
//   No ports (package).
// ----------------------------------------------------------------------------
package dcj11_pkg;

   // AIO codes. Bit 3 set marks a read-class cycle, except NIO which runs no
   // data phase at all.
   localparam logic [3:0] AIO_NIO         = 4'b1111;
   localparam logic [3:0] AIO_GP_READ     = 4'b1110;
   localparam logic [3:0] AIO_IACK_READ   = 4'b1101;
   localparam logic [3:0] AIO_IREQ_READ   = 4'b1100;
   localparam logic [3:0] AIO_RMW_NOLOCK  = 4'b1011;
   localparam logic [3:0] AIO_RMW_LOCK    = 4'b1010;
   localparam logic [3:0] AIO_DATA_READ   = 4'b1001;
   localparam logic [3:0] AIO_DEMAND_READ = 4'b1000;
   localparam logic [3:0] AIO_GP_WRITE    = 4'b0101;
   localparam logic [3:0] AIO_BYTE_WRITE  = 4'b0011;
   localparam logic [3:0] AIO_WORD_WRITE  = 4'b0001;

   // Bank-select codes
   localparam logic [1:0] BS_MEM  = 2'b00;
   localparam logic [1:0] BS_RSVD = 2'b01;
   localparam logic [1:0] BS_SYS  = 2'b10;
   localparam logic [1:0] BS_IO   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADR_LO = 3'd1,
      ST_ADR_HI = 3'd2,
      ST_TURN   = 3'd3,
      ST_STRB   = 3'd4,
      ST_WAITC  = 3'd5,
      ST_ENDC   = 3'd6
   } state_t;

   // High address word: bit0=a20, bit6=bs0, bit7=bs1, bit8=a21, bits12:9=a19:a16
   function automatic logic [15:0] pack_addr_hi(input logic [21:0] addr,
                                                input logic [1:0]  bs);
      pack_addr_hi = {3'b000, addr[19:16], addr[21], bs[1], bs[0],
                      5'b00000, addr[20]};
   endfunction

endpackage

// File: rtl/dcj11_bus_initiator.sv
// ----------------------------------------------------------------------------
// dcj11_bus_initiator
//   CPU-side master for the DCJ11 multiplexed DAL bus. Accepts one command at
//   a time and sequences address (lo, hi), optional turnaround, strobe and
//   end phases, returning read data with NXM / timeout status.
//
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high; cmd_* must be stable while cmd_valid is high and
//   unaccepted. rsp_valid is a single-cycle pulse with no back-pressure.
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     cmd_valid/cmd_ready             command handshake
//     cmd_aio, cmd_bs, cmd_addr,      command fields (GP cycles carry the GP
//     cmd_wdata                       code in cmd_addr[7:0])
//     rsp_valid, rsp_rdata,           response pulse, read data (held),
//     rsp_nxm, rsp_timeout            status flags (valid with the pulse)
//     ale_n, sctl_n, bufctl_n, aio    bus control
//     dal_out, dal_oe, dal_in         DAL drive value, enable, sampled value
//     nxm_n, cont_n                   responder status inputs
//     dbg_state                       current FSM state
//   All outputs are registered so reset reaches the pins immediately.
// ----------------------------------------------------------------------------
module dcj11_bus_initiator
   import dcj11_pkg::*;
#(
   parameter int T_ADR    = 2,
   parameter int T_STRB   = 4,
   parameter int WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_aio,
   input  logic [1:0]  cmd_bs,
   input  logic [21:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_nxm,
   output logic        rsp_timeout,
   output logic        ale_n,
   output logic        sctl_n,
   output logic        bufctl_n,
   output logic [3:0]  aio,
   output logic [15:0] dal_out,
   output logic        dal_oe,
   input  logic [15:0] dal_in,
   input  logic        nxm_n,
   input  logic        cont_n,
   output state_t      dbg_state
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] ADR_LAST  = CNT_W'(T_ADR - 1);
   localparam logic [CNT_W-1:0] STRB_LAST = CNT_W'(T_STRB - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         lat_aio_q, lat_aio_d;
   logic [1:0]         lat_bs_q, lat_bs_d;
   logic [21:0]        lat_addr_q, lat_addr_d;
   logic [15:0]        lat_wdata_q, lat_wdata_d;
   logic               nxm_q, nxm_d;

   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [15:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_nxm_q, rsp_nxm_d;
   logic               rsp_timeout_q, rsp_timeout_d;
   logic               ale_n_q, ale_n_d;
   logic               sctl_n_q, sctl_n_d;
   logic               bufctl_n_q, bufctl_n_d;
   logic [3:0]         aio_q, aio_d;
   logic [15:0]        dal_out_q, dal_out_d;
   logic               dal_oe_q, dal_oe_d;

   logic               strobe_phase, nxm_seen, timeout, capture;
   logic               is_read_q, is_nio_q, is_read_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      lat_aio_d   = lat_aio_q;
      lat_bs_d    = lat_bs_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      timeout     = 1'b0;
      capture     = 1'b0;

      is_nio_q     = (lat_aio_q == AIO_NIO);
      is_read_q    = lat_aio_q[3] & ~is_nio_q;
      strobe_phase = (state_q == ST_STRB) || (state_q == ST_WAITC);
      nxm_seen     = nxm_q | (strobe_phase & ~nxm_n);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (cmd_valid && cmd_ready_q) begin
               lat_aio_d   = cmd_aio;
               lat_bs_d    = cmd_bs;
               lat_addr_d  = cmd_addr;
               lat_wdata_d = cmd_wdata;
               state_d     = ST_ADR_LO;
            end
         end
         ST_ADR_LO: begin
            if (cnt_q == ADR_LAST) begin
               cnt_d   = '0;
               state_d = ST_ADR_HI;
            end
         end
         ST_ADR_HI: begin
            if (cnt_q == ADR_LAST) begin
               cnt_d = '0;
               if (is_nio_q)       state_d = ST_ENDC;
               else if (is_read_q) state_d = ST_TURN;
               else                state_d = ST_STRB;
            end
         end
         ST_TURN: begin
            cnt_d   = '0;
            state_d = ST_STRB;
         end
         ST_STRB: begin
            if (cnt_q == STRB_LAST) begin
               cnt_d = '0;
               if (!cont_n) begin
                  capture = 1'b1;
                  state_d = ST_ENDC;
               end else begin
                  state_d = ST_WAITC;
               end
            end
         end
         ST_WAITC: begin
            // cont_n low wins over an expiring wait budget on the same cycle
            if (!cont_n) begin
               capture = 1'b1;
               state_d = ST_ENDC;
            end else if (cnt_q == WAIT_LAST) begin
               timeout = 1'b1;
               state_d = ST_ENDC;
            end
         end
         ST_ENDC: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      if (capture && is_read_q) rsp_rdata_d = dal_in;
      if (timeout && is_read_q) rsp_rdata_d = 16'hFFFF;

      // Sticky NXM is handed to the response and cleared in the same step
      nxm_d         = (state_d == ST_ENDC) ? 1'b0 : nxm_seen;
      rsp_valid_d   = (state_d == ST_ENDC);
      rsp_nxm_d     = (state_d == ST_ENDC) & nxm_seen;
      rsp_timeout_d = timeout;

      // Output decode from the next state so the registered pins line up
      // with the state they belong to.
      is_read_d   = lat_aio_d[3] & (lat_aio_d != AIO_NIO);
      cmd_ready_d = (state_d == ST_IDLE);
      ale_n_d     = 1'b1;
      sctl_n_d    = 1'b1;
      bufctl_n_d  = 1'b1;
      aio_d       = AIO_NIO;
      dal_out_d   = 16'h0000;
      dal_oe_d    = 1'b0;
      case (state_d)
         ST_ADR_LO: begin
            ale_n_d   = 1'b0;
            dal_oe_d  = 1'b1;
            aio_d     = lat_aio_d;
            dal_out_d = lat_addr_d[15:0];
         end
         ST_ADR_HI: begin
            ale_n_d   = 1'b0;
            dal_oe_d  = 1'b1;
            aio_d     = lat_aio_d;
            dal_out_d = pack_addr_hi(lat_addr_d, lat_bs_d);
         end
         ST_TURN: begin
            aio_d = lat_aio_d;
         end
         ST_STRB, ST_WAITC: begin
            sctl_n_d = 1'b0;
            aio_d    = lat_aio_d;
            if (is_read_d) begin
               bufctl_n_d = 1'b0;
            end else begin
               dal_oe_d  = 1'b1;
               dal_out_d = lat_wdata_d;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         lat_aio_q     <= AIO_NIO;
         lat_bs_q      <= 2'b00;
         lat_addr_q    <= '0;
         lat_wdata_q   <= '0;
         nxm_q         <= 1'b0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 16'h0000;
         rsp_nxm_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         ale_n_q       <= 1'b1;
         sctl_n_q      <= 1'b1;
         bufctl_n_q    <= 1'b1;
         aio_q         <= AIO_NIO;
         dal_out_q     <= 16'h0000;
         dal_oe_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lat_aio_q     <= lat_aio_d;
         lat_bs_q      <= lat_bs_d;
         lat_addr_q    <= lat_addr_d;
         lat_wdata_q   <= lat_wdata_d;
         nxm_q         <= nxm_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_nxm_q     <= rsp_nxm_d;
         rsp_timeout_q <= rsp_timeout_d;
         ale_n_q       <= ale_n_d;
         sctl_n_q      <= sctl_n_d;
         bufctl_n_q    <= bufctl_n_d;
         aio_q         <= aio_d;
         dal_out_q     <= dal_out_d;
         dal_oe_q      <= dal_oe_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_nxm     = rsp_nxm_q;
   assign rsp_timeout = rsp_timeout_q;
   assign ale_n       = ale_n_q;
   assign sctl_n      = sctl_n_q;
   assign bufctl_n    = bufctl_n_q;
   assign aio         = aio_q;
   assign dal_out     = dal_out_q;
   assign dal_oe      = dal_oe_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_dcj11_bus_initiator.sv
// ----------------------------------------------------------------------------
// tb_dcj11_bus_initiator
//   Drives commands into dcj11_bus_initiator, plays a simple DAL responder
//   (cont_n hold-off, nxm_n pulse, read data) and compares every bus cycle
//   against expectations derived from the bus rules.
// ----------------------------------------------------------------------------
module tb_dcj11_bus_initiator;
   import dcj11_pkg::*;

   localparam int T_ADR    = 2;
   localparam int T_STRB   = 4;
   localparam int WAIT_MAX = 16;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_aio;
   logic [1:0]  cmd_bs;
   logic [21:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_nxm;
   logic        rsp_timeout;
   logic        ale_n;
   logic        sctl_n;
   logic        bufctl_n;
   logic [3:0]  aio;
   logic [15:0] dal_out;
   logic        dal_oe;
   logic [15:0] dal_in;
   logic        nxm_n;
   logic        cont_n;
   state_t      dbg_state;

   dcj11_bus_initiator #(
      .T_ADR(T_ADR), .T_STRB(T_STRB), .WAIT_MAX(WAIT_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_aio(cmd_aio),
      .cmd_bs(cmd_bs), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nxm(rsp_nxm),
      .rsp_timeout(rsp_timeout), .ale_n(ale_n), .sctl_n(sctl_n),
      .bufctl_n(bufctl_n), .aio(aio), .dal_out(dal_out), .dal_oe(dal_oe),
      .dal_in(dal_in), .nxm_n(nxm_n), .cont_n(cont_n), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [17:0] exp_q[$];        // {nxm, timeout, rdata} per issued command
   logic [15:0] model_rdata = 16'h0000;
   int          hi_run = 100;    // consecutive cycles with ale_n high
   logic [15:0] last_lo, last_hi;
   int          last_strb;
   logic        last_nxm, last_to;

   localparam logic [43:0] RST_VEC = {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0,
                                      1'b1, 1'b1, 1'b1, 4'hF, 16'h0000, 1'b0};

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [43:0] outs();
      return {cmd_ready, rsp_valid, rsp_rdata, rsp_nxm, rsp_timeout, ale_n,
              sctl_n, bufctl_n, aio, dal_out, dal_oe};
   endfunction

   // High address word from the bus rules, by arithmetic on field values
   function automatic logic [15:0] model_hi(input logic [21:0] a,
                                            input logic [1:0] bs);
      int ai, v;
      ai = int'(a);
      v  = ((ai >> 20) % 2) + int'(bs) * 64 + ((ai >> 21) % 2) * 256
           + ((ai >> 16) % 16) * 512;
      return v[15:0];
   endfunction

   // ---------------- driver + responder + monitor ----------------
   // hold: strobe cycles past T_STRB with cont_n high; nxm_at: strobe cycle
   // (1-based) on which nxm_n is low, 0 = never; abort_at: strobe cycle on
   // which reset is pulled, 0 = never.
   task automatic run_cmd(input logic [3:0] a_aio, input logic [1:0] a_bs,
                          input logic [21:0] a_addr, input logic [15:0] a_wdata,
                          input logic [15:0] a_rdata, input int hold,
                          input int nxm_at, input int abort_at);
      bit          is_nio, is_read, got_rsp;
      int          ale_i, k, len, addr_err, strb_err, conflict, gap, rsp_cnt;
      int          exp_strb;
      bit          exp_to, exp_nxm, endc_ok;
      logic [15:0] exp_lo, exp_hi, w;
      logic [17:0] got, exp;

      is_nio   = (a_aio == AIO_NIO);
      is_read  = a_aio[3] && !is_nio;
      exp_lo   = a_addr[15:0];
      exp_hi   = model_hi(a_addr, a_bs);
      exp_strb = is_nio ? 0 : T_STRB + ((hold < WAIT_MAX) ? hold : WAIT_MAX);
      exp_to   = !is_nio && (hold > WAIT_MAX);
      exp_nxm  = !is_nio && (nxm_at >= 1) && (nxm_at <= exp_strb);
      ale_i = 0; k = 0; len = 0; addr_err = 0; strb_err = 0; conflict = 0;
      gap = -1; rsp_cnt = 0; got_rsp = 0; endc_ok = 0; got = '0;

      @(negedge clk);
      if (ale_n) hi_run++;
      check("rdata_hold", rsp_rdata, model_rdata);
      cmd_aio = a_aio; cmd_bs = a_bs; cmd_addr = a_addr; cmd_wdata = a_wdata;
      cmd_valid = 1'b1;
      for (int b = 0; b < 20 && !cmd_ready; b++) begin
         @(negedge clk);
         if (ale_n) hi_run++;
      end
      check("accept_ready", cmd_ready, 1'b1);

      if (abort_at == 0) begin
         if (is_read) model_rdata = exp_to ? 16'hFFFF : a_rdata;
         exp_q.push_back({exp_nxm, exp_to, model_rdata});
      end

      for (int c = 0; c < 120 && !got_rsp; c++) begin
         @(negedge clk);
         if (c == 0) cmd_valid = 1'b0;
         len++;
         if (!ale_n) begin
            if (ale_i == 0) gap = hi_run;
            hi_run = 0;
            w = (ale_i < T_ADR) ? exp_lo : exp_hi;
            if (dal_out !== w || dal_oe !== 1'b1 || aio !== a_aio) addr_err++;
            if (ale_i == T_ADR - 1)   last_lo = dal_out;
            if (ale_i == 2*T_ADR - 1) last_hi = dal_out;
            ale_i++;
         end else begin
            hi_run++;
         end
         if (dal_oe && !bufctl_n) conflict++;
         if (rsp_valid) begin
            got_rsp = 1;
            got     = {rsp_nxm, rsp_timeout, rsp_rdata};
            endc_ok = ale_n && sctl_n && bufctl_n && !dal_oe && (aio == 4'hF);
         end
         if (!sctl_n) begin
            k++;
            if (abort_at > 0 && k == abort_at) begin
               rst_n = 1'b0;
               #1;
               check("abort_reset_vals", outs(), RST_VEC);
               for (int r = 0; r < 3; r++) begin
                  @(negedge clk);
                  if (rsp_valid) rsp_cnt++;
               end
               check("abort_no_rsp", rsp_cnt, 0);
               cont_n = 1'b1; nxm_n = 1'b1;
               rst_n = 1'b1;
               model_rdata = 16'h0000;
               hi_run = 100;
               return;
            end
            if (is_read) begin
               if (dal_oe !== 1'b0 || bufctl_n !== 1'b0) strb_err++;
            end else begin
               if (dal_oe !== 1'b1 || bufctl_n !== 1'b1 || dal_out !== a_wdata)
                  strb_err++;
            end
            cont_n = (k < T_STRB + hold) ? 1'b1 : 1'b0;
            nxm_n  = (k == nxm_at) ? 1'b0 : 1'b1;
            dal_in = a_rdata;
         end else begin
            cont_n = 1'b1;
            nxm_n  = 1'b1;
            dal_in = 16'($urandom);
         end
      end

      check("rsp_seen", got_rsp, 1'b1);
      check("addr_cycles", ale_i, 2*T_ADR);
      check("addr_phase_err", addr_err, 0);
      check("addr_hi_word", last_hi, exp_hi);
      check("strobe_len", k, exp_strb);
      check("strobe_drive_err", strb_err, 0);
      check("dal_conflict", conflict, 0);
      check("cycle_len", len, 2*T_ADR + (is_read ? 1 : 0) + exp_strb + 1);
      check("endc_bus_idle", endc_ok, 1'b1);
      check("ale_gap_ge2", (gap >= 2), 1'b1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
      check("rsp_fields", got, exp);
      last_strb = k;
      last_nxm  = got[17];
      last_to   = got[16];
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [3:0]  codes [0:6];
      logic [3:0]  ra;
      int          rh, rn;
      codes[0] = AIO_DATA_READ;  codes[1] = AIO_DEMAND_READ;
      codes[2] = AIO_GP_READ;    codes[3] = AIO_WORD_WRITE;
      codes[4] = AIO_BYTE_WRITE; codes[5] = AIO_GP_WRITE;
      codes[6] = AIO_NIO;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_aio = 4'hF; cmd_bs = 2'b00;
      cmd_addr = '0; cmd_wdata = '0; dal_in = '0; nxm_n = 1'b1; cont_n = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_vals", outs(), RST_VEC);
      rst_n = 1'b1;

      // Plain data read
      run_cmd(AIO_DATA_READ, BS_MEM, 22'o1000, 16'h0, 16'o123456, 0, 0, 0);
      check("read_lo_word", last_lo, 16'h0200);
      check("read_hi_word", last_hi, 16'h0000);
      check("read_rdata", rsp_rdata, 16'hA72E);
      check("read_strobe4", last_strb, 4);

      // Word write into the I/O page
      run_cmd(AIO_WORD_WRITE, BS_SYS, 22'o17777566, 16'h0041, 16'h1234, 0, 0, 0);
      check("write_hi_word", last_hi, 16'h1F81);

      // NXM on strobe cycle 2, then a clean read
      run_cmd(AIO_DATA_READ, BS_MEM, 22'o17760000, 16'h0, 16'h5A5A, 0, 2, 0);
      check("nxm_set", last_nxm, 1'b1);
      run_cmd(AIO_DATA_READ, BS_MEM, 22'o0, 16'h0, 16'h0F0F, 0, 0, 0);
      check("nxm_cleared", last_nxm, 1'b0);

      // Wait states and timeout
      run_cmd(AIO_DATA_READ, BS_MEM, 22'o2000, 16'h0, 16'hBEEF, 3, 0, 0);
      check("wait3_strobe", last_strb, 7);
      check("wait3_no_to", last_to, 1'b0);
      run_cmd(AIO_DATA_READ, BS_MEM, 22'o2002, 16'h0, 16'hCAFE, 20, 0, 0);
      check("to_strobe", last_strb, 20);
      check("to_flag", last_to, 1'b1);
      check("to_rdata", rsp_rdata, 16'hFFFF);

      // GP read of the power-up word, then NIO back-to-back
      run_cmd(AIO_GP_READ, BS_MEM, 22'o000, 16'h0, 16'o173001, 0, 0, 0);
      run_cmd(AIO_NIO, BS_MEM, 22'o0, 16'h0, 16'h0, 0, 0, 0);
      check("nio_no_strobe", last_strb, 0);

      // Reset in the middle of a strobe, then a normal command
      run_cmd(AIO_DATA_READ, BS_MEM, 22'o4000, 16'h0, 16'h7777, 0, 0, 2);
      run_cmd(AIO_BYTE_WRITE, BS_IO, 22'o17777001, 16'h00A5, 16'h0, 1, 0, 0);

      // Randomised commands
      for (int i = 0; i < 14; i++) begin
         ra = codes[$urandom_range(0, 6)];
         rh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                           : $urandom_range(0, 2);
         rn = $urandom_range(0, 7);
         run_cmd(ra, 2'($urandom_range(0, 3)), 22'($urandom),
                 16'($urandom), 16'($urandom), rh, rn, 0);
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
